drive_controller: RTL and testbench

- Sequences the vehicle speed profile and gates the distance accumulator (`counter_distance`) so it advances once per 0.1 s tick instead of every clock.
- Runs a STOP/ACCEL/CRUISE/BRAKE state machine from the accel and brake pedal inputs, and drives a 7-bit velocity in km/h.
- Turns the accumulator's 1 km carry pulses into an odometer count and a clearable trip count.
- Sits between the pedal/button debouncers and `counter_distance` + display logic.

---
 rtl/drive_pkg.sv | 36 +++
 rtl/tick_prescaler.sv | 27 ++
 rtl/drive_controller.sv | 113 +++++++++++
 tb/tb_drive_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/drive_pkg.sv
// Shared types, widths and saturating velocity helpers for the drive controller.
package drive_pkg;

  localparam int VEL_W  = 7;
  localparam int ODO_W  = 14;
  localparam int TRIP_W = 10;

  typedef enum logic [1:0] {
    S_STOP   = 2'd0,
    S_ACCEL  = 2'd1,
    S_CRUISE = 2'd2,
    S_BRAKE  = 2'd3
  } state_t;

  localparam logic [1:0] STATE_STOP   = 2'd0;
  localparam logic [1:0] STATE_ACCEL  = 2'd1;
  localparam logic [1:0] STATE_CRUISE = 2'd2;
  localparam logic [1:0] STATE_BRAKE  = 2'd3;

  // 8-bit intermediates keep the sum from wrapping before the ceiling compare.
  function automatic logic [VEL_W-1:0] sat_add(input logic [VEL_W-1:0] v,
                                               input logic [7:0] step,
                                               input logic [7:0] vmax);
    logic [7:0] sum;
    sum = {1'b0, v} + step;
    return (sum > vmax) ? vmax[VEL_W-1:0] : sum[VEL_W-1:0];
  endfunction

  function automatic logic [VEL_W-1:0] sat_sub(input logic [VEL_W-1:0] v,
                                               input logic [7:0] step);
    logic [7:0] diff;
    diff = {1'b0, v} - step;
    return ({1'b0, v} > step) ? diff[VEL_W-1:0] : '0;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider; tick is high during the last clock of each TICK_DIV period.
module tick_prescaler #(
  parameter int TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] presc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + CW'(1);
    end
  end

  assign tick = (presc == LAST);

endmodule

// File: rtl/drive_controller.sv
// Pedal-driven speed FSM, distance-accumulator gating and odometer/trip counters.
// Optional overspeed flag is built when OVERSPEED_WARN_EN is defined.
module drive_controller
  import drive_pkg::*;
#(
  parameter int TICK_DIV   = 2_500_000,
  parameter int V_MAX      = 120,
  parameter int ACCEL_STEP = 2,
  parameter int BRAKE_STEP = 5,
  parameter int ODO_MAX    = 9999,
  parameter int TRIP_MAX   = 999
`ifdef OVERSPEED_WARN_EN
  ,
  parameter int V_LIMIT    = 100
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accel,
  input  logic              brake,
  input  logic              trip_clr,
  input  logic              dist_carry,
  output logic [VEL_W-1:0]  velocity,
  output logic [VEL_W-1:0]  dist_velocity,
  output logic [1:0]        state,
  output logic [ODO_W-1:0]  odo_km,
  output logic [TRIP_W-1:0] trip_km
`ifdef OVERSPEED_WARN_EN
  ,
  output logic              overspeed
`endif
);

  logic             tick;
  state_t           state_r;
  logic [VEL_W-1:0] vel_up;
  logic [VEL_W-1:0] vel_down;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign vel_up   = sat_add(velocity, 8'(ACCEL_STEP), 8'(V_MAX));
  assign vel_down = sat_sub(velocity, 8'(BRAKE_STEP));
  assign state    = state_r;

  // Velocity only moves on a tick when the FSM stays put; a transition holds it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_STOP;
      velocity      <= '0;
      dist_velocity <= '0;
    end else begin
      dist_velocity <= tick ? velocity : '0;
      case (state_r)
        S_STOP: begin
          velocity <= '0;
          if (accel && !brake) state_r <= S_ACCEL;
        end
        S_ACCEL: begin
          if (brake)       state_r  <= S_BRAKE;
          else if (!accel) state_r  <= S_CRUISE;
          else if (tick)   velocity <= vel_up;
        end
        S_CRUISE: begin
          if (brake)      state_r <= S_BRAKE;
          else if (accel) state_r <= S_ACCEL;
        end
        S_BRAKE: begin
          if (velocity == '0) state_r  <= S_STOP;
          else if (!brake)    state_r  <= accel ? S_ACCEL : S_CRUISE;
          else if (tick)      velocity <= vel_down;
        end
        default: state_r <= S_STOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odo_km  <= '0;
      trip_km <= '0;
    end else begin
      if (dist_carry) begin
        odo_km <= (odo_km == ODO_W'(ODO_MAX)) ? '0 : odo_km + ODO_W'(1);
      end
      if (trip_clr) begin
        trip_km <= '0;
      end else if (dist_carry) begin
        trip_km <= (trip_km == TRIP_W'(TRIP_MAX)) ? '0 : trip_km + TRIP_W'(1);
      end
    end
  end

`ifdef OVERSPEED_WARN_EN
  // Tracks the velocity register itself, so it follows each velocity write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overspeed <= 1'b0;
    end else begin
      case (state_r)
        S_STOP:  overspeed <= 1'b0;
        S_ACCEL: if (!brake && accel && tick) overspeed <= ({1'b0, vel_up} > 8'(V_LIMIT));
        S_BRAKE: if (velocity != '0 && brake && tick) overspeed <= ({1'b0, vel_down} > 8'(V_LIMIT));
        default: overspeed <= overspeed;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_drive_controller.sv
// Bench for drive_controller: cycle model with expected queue plus directed literal checks.
module tb_drive_controller;

  localparam int TD    = 4;
  localparam int VMAX  = 120;
  localparam int ASTEP = 2;
  localparam int BSTEP = 5;
  localparam int OMAX  = 9999;
  localparam int TMAX  = 999;

  logic        clk;
  logic        rst_n;
  logic        accel;
  logic        brake;
  logic        trip_clr;
  logic        dist_carry;
  logic [6:0]  velocity;
  logic [6:0]  dist_velocity;
  logic [1:0]  state;
  logic [13:0] odo_km;
  logic [9:0]  trip_km;
`ifdef OVERSPEED_WARN_EN
  logic        overspeed;
`endif

  int total = 0;
  int bad   = 0;

  drive_controller #(
    .TICK_DIV(TD), .V_MAX(VMAX), .ACCEL_STEP(ASTEP), .BRAKE_STEP(BSTEP),
    .ODO_MAX(OMAX), .TRIP_MAX(TMAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .accel         (accel),
    .brake         (brake),
    .trip_clr      (trip_clr),
    .dist_carry    (dist_carry),
    .velocity      (velocity),
    .dist_velocity (dist_velocity),
    .state         (state),
    .odo_km        (odo_km),
    .trip_km       (trip_km)
`ifdef OVERSPEED_WARN_EN
    ,
    .overspeed     (overspeed)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // behavioural model: elapsed cycles since reset, plain integer speed rules
  logic [39:0] exp_q[$];
  int  m_state, m_vel, m_dv, m_odo, m_trip, m_cyc;
  bit  m_tick;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = 0; m_vel = 0; m_dv = 0; m_odo = 0; m_trip = 0; m_cyc = 0;
    end else begin
      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_dv = m_tick ? m_vel : 0;
      case (m_state)
        0: begin
          m_vel = 0;
          if (accel && !brake) m_state = 1;
        end
        1: begin
          if (brake) m_state = 3;
          else if (!accel) m_state = 2;
          else if (m_tick) m_vel = (m_vel + ASTEP > VMAX) ? VMAX : m_vel + ASTEP;
        end
        2: begin
          if (brake) m_state = 3;
          else if (accel) m_state = 1;
        end
        default: begin
          if (m_vel == 0) m_state = 0;
          else if (!brake) m_state = accel ? 1 : 2;
          else if (m_tick) m_vel = (m_vel > BSTEP) ? m_vel - BSTEP : 0;
        end
      endcase
      if (dist_carry) m_odo = (m_odo == OMAX) ? 0 : m_odo + 1;
      if (trip_clr) m_trip = 0;
      else if (dist_carry) m_trip = (m_trip == TMAX) ? 0 : m_trip + 1;
    end
    exp_q.push_back({2'(m_state), 7'(m_vel), 7'(m_dv), 14'(m_odo), 10'(m_trip)});
  end

  // scoreboard compare, one entry per clock
  always @(negedge clk) begin
    logic [39:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_state", 32'(state), 32'(e[39:38]));
      check("sb_velocity", 32'(velocity), 32'(e[37:31]));
      check("sb_dist_velocity", 32'(dist_velocity), 32'(e[30:24]));
      check("sb_odo_km", 32'(odo_km), 32'(e[23:10]));
      check("sb_trip_km", 32'(trip_km), 32'(e[9:0]));
    end
  end

  // driver tasks: inputs change right after a falling edge
  task automatic wait_vel(input int v, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (velocity == 7'(v)) break;
      @(negedge clk);
    end
    check(name, 32'(velocity), 32'(v));
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (state == 2'(s)) break;
      @(negedge clk);
    end
    check(name, 32'(state), 32'(s));
  endtask

  task automatic carry_burst(input int n);
    dist_carry = 1'b1;
    repeat (n) @(negedge clk);
    dist_carry = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; accel = 1'b0; brake = 1'b0; trip_clr = 1'b0; dist_carry = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(state), 0);
    check("reset_velocity", 32'(velocity), 0);
    check("reset_odo", 32'(odo_km), 0);
    rst_n = 1'b1;

    // accelerate to the ceiling
    accel = 1'b1;
    repeat (70 * TD + 4) @(negedge clk);
    check("accel_saturate", 32'(velocity), 120);
    check("accel_state", 32'(state), 1);

    // brake all the way down, then climb to 12
    accel = 1'b0; brake = 1'b1;
    wait_state(0, 200, "brake_to_stop");
    brake = 1'b0; accel = 1'b1;
    wait_vel(12, 100, "reach_12");
    accel = 1'b0;
    @(negedge clk);
    check("cruise_state", 32'(state), 2);
    check("cruise_velocity", 32'(velocity), 12);
    repeat (6) @(negedge clk);
    check("cruise_hold", 32'(velocity), 12);
    brake = 1'b1;
    @(negedge clk);
    check("brake_state", 32'(state), 3);
    wait_vel(7, 10, "brake_7");
    wait_vel(2, 10, "brake_2");
    wait_vel(0, 10, "brake_0");
    wait_state(0, 3, "brake_stop");
    repeat (3) @(negedge clk);
    check("stop_no_underflow", 32'(velocity), 0);
    brake = 1'b0;

    // both pedals from CRUISE: brake wins
    accel = 1'b1;
    repeat (3) @(negedge clk);
    accel = 1'b0;
    @(negedge clk);
    check("to_cruise", 32'(state), 2);
    accel = 1'b1; brake = 1'b1;
    @(negedge clk);
    check("both_pedals_brake", 32'(state), 3);
    accel = 1'b0;
    repeat (40) @(negedge clk);
    check("settle_stop", 32'(state), 0);
    brake = 1'b0;

    // odometer and trip
    repeat (3) begin
      dist_carry = 1'b1;
      @(negedge clk);
      dist_carry = 1'b0;
      @(negedge clk);
    end
    check("odo_3", 32'(odo_km), 3);
    check("trip_3", 32'(trip_km), 3);
    dist_carry = 1'b1; trip_clr = 1'b1;
    @(negedge clk);
    dist_carry = 1'b0; trip_clr = 1'b0;
    check("clr_trip_0", 32'(trip_km), 0);
    check("clr_odo_4", 32'(odo_km), 4);

    carry_burst(8995);
    check("odo_8999", 32'(odo_km), 8999);
    check("trip_995", 32'(trip_km), 995);
    dist_carry = 1'b1; trip_clr = 1'b1;
    @(negedge clk);
    dist_carry = 1'b0; trip_clr = 1'b0;
    carry_burst(999);
    check("odo_max", 32'(odo_km), 9999);
    check("trip_max", 32'(trip_km), 999);
    carry_burst(1);
    check("odo_wrap", 32'(odo_km), 0);
    check("trip_wrap", 32'(trip_km), 0);

    // reset mid-tick while accelerating
    accel = 1'b1;
    wait_vel(50, 200, "reach_50");
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_velocity", 32'(velocity), 0);
    check("midrst_state", 32'(state), 0);
    check("midrst_dist_velocity", 32'(dist_velocity), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_tick", 32'(velocity), 0);
    @(negedge clk);
    check("post_rst_first_tick", 32'(velocity), 2);
    repeat (4) @(negedge clk);
    check("post_rst_dv_pulse", 32'(dist_velocity), 2);
    accel = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
